// File: rtl/axis_packet_stats_if.sv
// AXI-Stream bundle used by axis_packet_stats for both its sample input and summary output.
interface axis_packet_stats_if #(
  parameter int DATA_W = 32
);
  logic [DATA_W-1:0]   TDATA;
  logic [DATA_W/8-1:0] TKEEP;
  logic                TLAST;
  logic                TVALID;
  logic                TREADY;

  modport master (output TDATA, TKEEP, TLAST, TVALID, input TREADY);
  modport slave  (input TDATA, TKEEP, TLAST, TVALID, output TREADY);
endinterface

// File: rtl/axis_packet_stats.sv
// Per-packet count/min/max/sum over filtered samples; one 4-beat summary packet per input packet.
module axis_packet_stats #(
  parameter int SAT_SUM = 1,
  parameter int DATA_W  = 32
) (
  input  logic                       ACLK,
  input  logic                       ARESETN,
  axis_packet_stats_if.slave         S_AXIS,
  axis_packet_stats_if.master        M_AXIS
);

  typedef enum logic {ACCUM, EMIT} state_t;

  state_t            r_state, w_state_n;
  logic [DATA_W-1:0] r_cnt, r_min, r_max, r_sum;
  logic [DATA_W-1:0] w_cnt_n, w_min_n, w_max_n, w_sum_n;
  logic [1:0]        r_beat_idx, w_beat_idx_n;
  logic [DATA_W:0]   w_sum_wide;
  logic [DATA_W-1:0] w_sum_upd;
  logic [DATA_W-1:0] w_d;

  assign w_d        = S_AXIS.TDATA;
  assign w_sum_wide = {1'b0, r_sum} + {1'b0, w_d};
  assign w_sum_upd  = ((SAT_SUM != 0) && w_sum_wide[DATA_W]) ? '1 : w_sum_wide[DATA_W-1:0];

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      r_state    <= ACCUM;
      r_cnt      <= '0;
      r_min      <= '1;
      r_max      <= '0;
      r_sum      <= '0;
      r_beat_idx <= '0;
    end else begin
      r_state    <= w_state_n;
      r_cnt      <= w_cnt_n;
      r_min      <= w_min_n;
      r_max      <= w_max_n;
      r_sum      <= w_sum_n;
      r_beat_idx <= w_beat_idx_n;
    end
  end

  always_comb begin
    w_state_n    = r_state;
    w_cnt_n      = r_cnt;
    w_min_n      = r_min;
    w_max_n      = r_max;
    w_sum_n      = r_sum;
    w_beat_idx_n = r_beat_idx;
    case (r_state)
      ACCUM: begin
        if (S_AXIS.TVALID) begin
          w_cnt_n = (r_cnt == '1) ? r_cnt : r_cnt + 1'b1;
          w_min_n = (w_d < r_min) ? w_d : r_min;
          w_max_n = (w_d > r_max) ? w_d : r_max;
          w_sum_n = w_sum_upd;
          if (S_AXIS.TLAST) begin
            w_state_n    = EMIT;
            w_beat_idx_n = '0;
          end
        end
      end
      EMIT: begin
        if (M_AXIS.TREADY) begin
          if (r_beat_idx == 2'd3) begin
            // Final summary handshake clears statistics so the next packet starts fresh.
            w_state_n    = ACCUM;
            w_cnt_n      = '0;
            w_min_n      = '1;
            w_max_n      = '0;
            w_sum_n      = '0;
            w_beat_idx_n = '0;
          end else begin
            w_beat_idx_n = r_beat_idx + 2'd1;
          end
        end
      end
      default: w_state_n = ACCUM;
    endcase
  end

  assign S_AXIS.TREADY = (r_state == ACCUM);
  assign M_AXIS.TVALID = (r_state == EMIT);
  assign M_AXIS.TLAST  = (r_state == EMIT) && (r_beat_idx == 2'd3);
  assign M_AXIS.TKEEP  = '1;

  always_comb begin
    M_AXIS.TDATA = '0;
    if (r_state == EMIT) begin
      case (r_beat_idx)
        2'd0:    M_AXIS.TDATA = r_cnt;
        2'd1:    M_AXIS.TDATA = r_min;
        2'd2:    M_AXIS.TDATA = r_max;
        default: M_AXIS.TDATA = r_sum;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_packet_stats.sv
// Directed bench for axis_packet_stats: summaries, saturation/wrap, backpressure, reset, back-to-back.
module tb_axis_packet_stats;

  logic ACLK = 1'b0;
  logic ARESETN;
  always #5 ACLK = ~ACLK;

  axis_packet_stats_if #(.DATA_W(32)) s_if ();
  axis_packet_stats_if #(.DATA_W(32)) m_if ();
  axis_packet_stats_if #(.DATA_W(32)) s_if0 ();
  axis_packet_stats_if #(.DATA_W(32)) m_if0 ();

  axis_packet_stats #(.SAT_SUM(1), .DATA_W(32)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN), .S_AXIS(s_if.slave), .M_AXIS(m_if.master)
  );
  axis_packet_stats #(.SAT_SUM(0), .DATA_W(32)) dut_wrap (
    .ACLK(ACLK), .ARESETN(ARESETN), .S_AXIS(s_if0.slave), .M_AXIS(m_if0.master)
  );

  assign s_if0.TDATA  = s_if.TDATA;
  assign s_if0.TKEEP  = s_if.TKEEP;
  assign s_if0.TLAST  = s_if.TLAST;
  assign s_if0.TVALID = s_if.TVALID;
  assign m_if0.TREADY = m_if.TREADY;

  int passed = 0;
  int total  = 0;
  logic [31:0] pkt [0:7];
  int pkt_len;

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  // Presents pkt[0..pkt_len-1]; TLAST on the final beat only when with_last is set.
  task automatic send_pkt(input bit with_last);
    for (int i = 0; i < pkt_len; i++) begin
      s_if.TVALID = 1'b1;
      s_if.TDATA  = pkt[i];
      s_if.TLAST  = with_last && (i == pkt_len - 1);
      tick();
    end
    s_if.TVALID = 1'b0;
    s_if.TLAST  = 1'b0;
  endtask

  task automatic apply_reset();
    ARESETN = 1'b0;
    tick();
    tick();
    ARESETN = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    total++;
    if (m_if.TVALID !== 1'b0 || m_if.TLAST !== 1'b0 || m_if.TDATA !== 32'h0 || s_if.TREADY !== 1'b1) begin
      $display("FAIL reset_state: tvalid=%b tlast=%b tdata=%h s_tready=%b, required 0 0 00000000 1",
               m_if.TVALID, m_if.TLAST, m_if.TDATA, s_if.TREADY);
    end else passed++;
  endtask

  task automatic test_basic();
    logic [31:0] exp [0:3];
    int low_cycles;
    exp[0] = 32'd4; exp[1] = 32'd5; exp[2] = 32'd30; exp[3] = 32'd65;
    pkt[0] = 32'd10; pkt[1] = 32'd20; pkt[2] = 32'd30; pkt[3] = 32'd5; pkt_len = 4;
    m_if.TREADY = 1'b1;
    send_pkt(1'b1);
    low_cycles = 0;
    for (int b = 0; b < 4; b++) begin
      if (s_if.TREADY === 1'b0) low_cycles++;
      total++;
      if (m_if.TVALID !== 1'b1 || m_if.TDATA !== exp[b] || m_if.TLAST !== (b == 3)) begin
        $display("FAIL basic_beat%0d: tvalid=%b tdata=%0d tlast=%b, required 1 %0d %b",
                 b, m_if.TVALID, m_if.TDATA, m_if.TLAST, exp[b], (b == 3));
      end else passed++;
      tick();
    end
    total++;
    if (low_cycles != 4 || s_if.TREADY !== 1'b1 || m_if.TVALID !== 1'b0) begin
      $display("FAIL basic_tready_low: low_cycles=%0d s_tready=%b m_tvalid=%b, required 4 1 0",
               low_cycles, s_if.TREADY, m_if.TVALID);
    end else passed++;
  endtask

  task automatic test_single();
    logic [31:0] exp [0:3];
    exp[0] = 32'd1; exp[1] = 32'd7; exp[2] = 32'd7; exp[3] = 32'd7;
    pkt[0] = 32'd7; pkt_len = 1;
    send_pkt(1'b1);
    for (int b = 0; b < 4; b++) begin
      total++;
      if (m_if.TVALID !== 1'b1 || m_if.TDATA !== exp[b] || m_if.TLAST !== (b == 3)) begin
        $display("FAIL single_beat%0d: tvalid=%b tdata=%0d tlast=%b, required 1 %0d %b",
                 b, m_if.TVALID, m_if.TDATA, m_if.TLAST, exp[b], (b == 3));
      end else passed++;
      tick();
    end
  endtask

  task automatic test_sum_sat();
    logic [31:0] exp_sat [0:3];
    logic [31:0] exp_wrap [0:3];
    exp_sat[0]  = 32'd2; exp_sat[1]  = 32'h20; exp_sat[2]  = 32'hFFFF_FFF0; exp_sat[3]  = 32'hFFFF_FFFF;
    exp_wrap[0] = 32'd2; exp_wrap[1] = 32'h20; exp_wrap[2] = 32'hFFFF_FFF0; exp_wrap[3] = 32'h0000_0010;
    pkt[0] = 32'hFFFF_FFF0; pkt[1] = 32'h20; pkt_len = 2;
    send_pkt(1'b1);
    for (int b = 0; b < 4; b++) begin
      total++;
      if (m_if.TDATA !== exp_sat[b] || m_if0.TDATA !== exp_wrap[b]) begin
        $display("FAIL sum_beat%0d: sat=%h wrap=%h, required sat=%h wrap=%h",
                 b, m_if.TDATA, m_if0.TDATA, exp_sat[b], exp_wrap[b]);
      end else passed++;
      tick();
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] exp [0:3];
    exp[0] = 32'd2; exp[1] = 32'd3; exp[2] = 32'd9; exp[3] = 32'd12;
    pkt[0] = 32'd3; pkt[1] = 32'd9; pkt_len = 2;
    m_if.TREADY = 1'b1;
    send_pkt(1'b1);
    total++;
    if (m_if.TDATA !== exp[0]) begin
      $display("FAIL bp_beat0: tdata=%0d, required %0d", m_if.TDATA, exp[0]);
    end else passed++;
    tick();
    m_if.TREADY = 1'b0;
    for (int c = 0; c < 3; c++) begin
      total++;
      if (m_if.TVALID !== 1'b1 || m_if.TDATA !== 32'd3 || s_if.TREADY !== 1'b0) begin
        $display("FAIL bp_stall%0d: tvalid=%b tdata=%0d s_tready=%b, required 1 3 0",
                 c, m_if.TVALID, m_if.TDATA, s_if.TREADY);
      end else passed++;
      tick();
    end
    m_if.TREADY = 1'b1;
    for (int b = 1; b < 4; b++) begin
      total++;
      if (m_if.TVALID !== 1'b1 || m_if.TDATA !== exp[b] || m_if.TLAST !== (b == 3) || s_if.TREADY !== 1'b0) begin
        $display("FAIL bp_beat%0d: tvalid=%b tdata=%0d tlast=%b s_tready=%b, required 1 %0d %b 0",
                 b, m_if.TVALID, m_if.TDATA, m_if.TLAST, s_if.TREADY, exp[b], (b == 3));
      end else passed++;
      tick();
    end
  endtask

  task automatic test_mid_reset();
    logic [31:0] exp [0:3];
    exp[0] = 32'd2; exp[1] = 32'd100; exp[2] = 32'd200; exp[3] = 32'd300;
    pkt[0] = 32'd500; pkt[1] = 32'd1; pkt_len = 2;
    send_pkt(1'b0);
    apply_reset();
    pkt[0] = 32'd100; pkt[1] = 32'd200; pkt_len = 2;
    send_pkt(1'b1);
    for (int b = 0; b < 4; b++) begin
      total++;
      if (m_if.TVALID !== 1'b1 || m_if.TDATA !== exp[b]) begin
        $display("FAIL mid_reset_beat%0d: tvalid=%b tdata=%0d, required 1 %0d",
                 b, m_if.TVALID, m_if.TDATA, exp[b]);
      end else passed++;
      tick();
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp1 [0:3];
    logic [31:0] exp2 [0:3];
    exp1[0] = 32'd2; exp1[1] = 32'd1;  exp1[2] = 32'd2;  exp1[3] = 32'd3;
    exp2[0] = 32'd1; exp2[1] = 32'd50; exp2[2] = 32'd50; exp2[3] = 32'd50;
    s_if.TVALID = 1'b1;
    s_if.TDATA = 32'd1; s_if.TLAST = 1'b0;
    tick();
    s_if.TDATA = 32'd2; s_if.TLAST = 1'b1;
    tick();
    s_if.TDATA = 32'd50; s_if.TLAST = 1'b1;
    for (int b = 0; b < 4; b++) begin
      total++;
      if (m_if.TVALID !== 1'b1 || m_if.TDATA !== exp1[b] || m_if.TLAST !== (b == 3)) begin
        $display("FAIL b2b_pkt1_beat%0d: tvalid=%b tdata=%0d tlast=%b, required 1 %0d %b",
                 b, m_if.TVALID, m_if.TDATA, m_if.TLAST, exp1[b], (b == 3));
      end else passed++;
      tick();
    end
    total++;
    if (s_if.TREADY !== 1'b1 || m_if.TVALID !== 1'b0) begin
      $display("FAIL b2b_gap: s_tready=%b m_tvalid=%b, required 1 0", s_if.TREADY, m_if.TVALID);
    end else passed++;
    tick();
    s_if.TVALID = 1'b0;
    s_if.TLAST  = 1'b0;
    for (int b = 0; b < 4; b++) begin
      total++;
      if (m_if.TVALID !== 1'b1 || m_if.TDATA !== exp2[b] || m_if.TLAST !== (b == 3)) begin
        $display("FAIL b2b_pkt2_beat%0d: tvalid=%b tdata=%0d tlast=%b, required 1 %0d %b",
                 b, m_if.TVALID, m_if.TDATA, m_if.TLAST, exp2[b], (b == 3));
      end else passed++;
      tick();
    end
  endtask

  initial begin
    ARESETN     = 1'b0;
    s_if.TDATA  = '0;
    s_if.TKEEP  = '1;
    s_if.TLAST  = 1'b0;
    s_if.TVALID = 1'b0;
    m_if.TREADY = 1'b1;
    #1;
    test_reset();
    test_basic();
    test_single();
    test_sum_sat();
    test_backpressure();
    test_mid_reset();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/axis_packet_stats.md
Name: axis_packet_stats

Overview:
- Downstream consumer of the EMA filter's AXI-Stream output.
- Accumulates per-packet statistics over the filtered unsigned 32-bit samples; a packet is delimited by TLAST.
- After each packet, emits a 4-beat summary packet: count, min, max, sum.
- Feeds the DMA write path, so software reads one small record per frame instead of every sample.

Parameters:
- SAT_SUM, 1, 1 = sum saturates at 32'hFFFF_FFFF; 0 = sum wraps modulo 2^32.
- DATA_W, 32, sample and output width; only 32 is supported.

Ports:
- ACLK  in  1  clock.
- ARESETN  in  1  reset; synchronous, active-low (clock ACLK).
- S_AXIS_TDATA  in  32  filtered sample, unsigned.
- S_AXIS_TKEEP  in  4  ignored; every accepted beat counts as one full sample.
- S_AXIS_TLAST  in  1  last sample of the packet.
- S_AXIS_TVALID  in  1  upstream valid.
- S_AXIS_TREADY  out  1  high only in state ACCUM.
- M_AXIS_TDATA  out  32  summary word.
- M_AXIS_TKEEP  out  4  constant 4'hF.
- M_AXIS_TLAST  out  1  high on summary beat 3 only.
- M_AXIS_TVALID  out  1  summary beat valid.
- M_AXIS_TREADY  in  1  downstream ready.

Behaviour:
- Reset (ARESETN=0 at a rising ACLK edge):
  - state=ACCUM; cnt=0, min=32'hFFFF_FFFF, max=0, sum=0, beat_idx=0.
  - M_AXIS_TVALID=0, M_AXIS_TLAST=0, M_AXIS_TDATA=0; S_AXIS_TREADY=1 from the first post-reset cycle.
  - Reset mid-packet or mid-emit discards all partial statistics and any pending summary.
- Input handshake: a beat is accepted when S_AXIS_TVALID && S_AXIS_TREADY at a rising edge.
- State ACCUM (S_AXIS_TREADY=1, M_AXIS_TVALID=0):
  - On each accepted beat with sample d:
    - cnt <= cnt+1, saturating at 32'hFFFF_FFFF.
    - min <= (d < min) ? d : min, unsigned compare.
    - max <= (d > max) ? d : max, unsigned compare.
    - sum <= sum+d, computed with a 33-bit intermediate. SAT_SUM=1: if the carry is set, result is 32'hFFFF_FFFF. SAT_SUM=0: low 32 bits.
  - Statistics include the TLAST beat itself.
  - An accepted beat with TLAST=1: state <= EMIT, beat_idx <= 0, using the updated (post-beat) statistics.
- State EMIT (S_AXIS_TREADY=0):
  - M_AXIS_TVALID=1, registered; it rises the cycle after the TLAST beat is accepted (latency 1 cycle).
  - M_AXIS_TDATA by beat_idx: 0 = cnt, 1 = min, 2 = max, 3 = sum. Driven from registers and stable while TVALID && !TREADY.
  - M_AXIS_TLAST=1 iff beat_idx==3.
  - A handshake on beat_idx<3 increments beat_idx.
  - A handshake on beat_idx==3 does all of the following at once: state <= ACCUM; statistics return to reset values; M_AXIS_TVALID <= 0.
  - The next packet's first beat can be accepted the cycle after that final handshake.
- No simultaneous input/output transfers: the input is blocked during EMIT, so the minimum packet period is N+4 cycles for an N-sample packet with no backpressure.
- A single-sample packet is legal: count=1, min=max=sum=sample.
- TVALID dropping mid-packet only pauses accumulation; nothing times out.
- The design must never drop M_AXIS_TVALID without a handshake, and must never change M_AXIS_TDATA while stalled.

Test Plan:
- Samples 10,20,30,5 (TLAST on 5), M_AXIS_TREADY=1 → output beats 4, 5, 30, 65; TLAST on beat 4; S_AXIS_TREADY low for exactly 4 cycles.
- Single-sample packet 7 with TLAST → output beats 1, 7, 7, 7.
- Packet 32'hFFFF_FFF0, 32'h20 with SAT_SUM=1 → sum beat 32'hFFFF_FFFF. With SAT_SUM=0 → sum beat 32'h0000_0010.
- Backpressure: M_AXIS_TREADY low for 3 cycles on beat 1 of the packet {3,9} → TDATA held at 3 with TVALID high throughout; beat order 2, 3, 9, 12 unchanged; S_AXIS_TREADY stays 0.
- Reset asserted after 2 samples of a packet, then the packet {100,200} → summary 2, 100, 200, 300 (no residue from before the reset).
- Back-to-back packets {1,2} and {50}, upstream TVALID held high → summaries 2,1,2,3 then 1,50,50,50; second packet accepted the cycle after the first summary's TLAST handshake.
